// File: rtl/ppm_pkg.sv
// -----------------------------------------------------------------------------
// ppm_pkg
// Shared constants for the PPM frame scheduler.
//   POS_W       width of a pulse position (one slot = 2**POS_W ticks)
//   SLOT_TICKS  ticks per slot
//   IDX_W       width of a channel / slot index (up to 8 channels)
//   PRESC_W     width of the tick prescaler
//   ST_*        FSM state encodings, carried on state_t
// -----------------------------------------------------------------------------
package ppm_pkg;

   localparam int POS_W      = 8;
   localparam int SLOT_TICKS = 256;
   localparam int IDX_W      = 3;
   localparam int PRESC_W    = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SYNC = 2'd1;
   localparam state_t ST_SLOT = 2'd2;

endpackage

// File: rtl/ppm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ppm_rr_arbiter
// Purely combinational round-robin pick. Search starts at i_last_grant+1 and
// wraps modulo NCH; the first requesting channel wins.
//   i_req         per-channel request
//   i_last_grant  channel granted most recently
//   o_grant       one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module ppm_rr_arbiter
   import ppm_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]   i_req,
   input  logic [IDX_W-1:0] i_last_grant,
   output logic [NCH-1:0]   o_grant
);

   logic w_found;

   // Two passes replace a modulo search: first the channels above the last
   // winner, then wrap around to channel 0 up to the last winner itself.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!w_found && (i > int'(i_last_grant)) && i_req[i]) begin
            o_grant[i] = 1'b1;
            w_found    = 1'b1;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (!w_found && (i <= int'(i_last_grant)) && i_req[i]) begin
            o_grant[i] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ppm_frame_sched.sv
// -----------------------------------------------------------------------------
// ppm_frame_sched
// Shares one PPM pulse timeline between NCH requesters. A frame is a sync
// interval of SYNC_TICKS ticks followed by NCH slots of 256 ticks. At the start
// of every slot one pending requester is granted round-robin, its position is
// latched and one pulse is emitted at that position inside the slot.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         allow new frames to start
//   req_valid[i]   channel i has a pulse pending
//   req_pos        channel i position at bits [8i+7:8i]
//   req_ready[i]   one-clk accept strobe for channel i
//   pulse_out      PPM pulse, one tick period wide, one clk behind the count
//   sync_out       high during the sync interval
//   frame_start    one-clk strobe on entry to SYNC
//   busy           FSM not IDLE (doubles as a state debug view)
//   slot_idx       current slot, 0 outside SLOT
//
// Handshake: a channel raises req_valid with a stable req_pos and keeps both
// until it sees req_ready; the transfer happens in the clk where
// req_valid & req_ready are both high. req_ready is only ever asserted in the
// first clk of a slot and for at most one channel.
// -----------------------------------------------------------------------------
module ppm_frame_sched
   import ppm_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int PRESC      = 1,
   parameter int SYNC_TICKS = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [NCH-1:0]       req_valid,
   input  logic [POS_W*NCH-1:0] req_pos,
   output logic [NCH-1:0]       req_ready,
   output logic                 pulse_out,
   output logic                 sync_out,
   output logic                 frame_start,
   output logic                 busy,
   output logic [IDX_W-1:0]     slot_idx
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
   localparam logic [POS_W-1:0]   SYNC_LAST  = POS_W'(SYNC_TICKS - 1);
   localparam logic [POS_W-1:0]   SLOT_LAST  = POS_W'(SLOT_TICKS - 1);
   localparam logic [IDX_W-1:0]   LAST_CH    = IDX_W'(NCH - 1);

   state_t             r_state;
   logic [PRESC_W-1:0] r_presc;
   logic [POS_W-1:0]   r_sync_cnt;
   logic [POS_W-1:0]   r_slot_cnt;
   logic [IDX_W-1:0]   r_slot_idx;
   logic [IDX_W-1:0]   r_last_grant;
   logic               r_arb;
   logic               r_slot_vld;
   logic [POS_W-1:0]   r_pos;
   logic               r_pulse;
   logic               r_sync;
   logic               r_fstart;

   logic               w_tick;
   logic               w_start;
   logic               w_arb_clk;
   logic [NCH-1:0]     w_grant;
   logic               w_gnt_any;
   logic [POS_W-1:0]   w_sel_pos;
   logic [IDX_W-1:0]   w_sel_idx;
   logic               w_cur_vld;
   logic [POS_W-1:0]   w_cur_pos;

   ppm_rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );

   assign w_tick    = (r_state != ST_IDLE) && (r_presc == PRESC_LAST);
   assign w_start   = enable && (|req_valid);
   assign w_arb_clk = (r_state == ST_SLOT) && r_arb;
   assign w_gnt_any = |w_grant;

   always_comb begin
      w_sel_pos = '0;
      w_sel_idx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant[i]) begin
            w_sel_pos = req_pos[i*POS_W +: POS_W];
            w_sel_idx = IDX_W'(i);
         end
      end
   end

   // In the arbitration clk the grant is not latched yet; use it directly so
   // a position of 0 still pulses in the first tick period of the slot.
   assign w_cur_vld = r_arb ? w_gnt_any : r_slot_vld;
   assign w_cur_pos = r_arb ? w_sel_pos : r_pos;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_presc      <= '0;
         r_sync_cnt   <= '0;
         r_slot_cnt   <= '0;
         r_slot_idx   <= '0;
         r_last_grant <= LAST_CH;
         r_arb        <= 1'b0;
         r_slot_vld   <= 1'b0;
         r_pos        <= '0;
         r_pulse      <= 1'b0;
         r_sync       <= 1'b0;
         r_fstart     <= 1'b0;
      end else begin
         r_fstart <= 1'b0;

         // Prescaler only runs inside a frame, so every frame starts aligned.
         if ((r_state == ST_IDLE) || w_tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PRESC_W'(1);
         end

         if (w_arb_clk) begin
            r_arb      <= 1'b0;
            r_slot_vld <= w_gnt_any;
            if (w_gnt_any) begin
               r_pos        <= w_sel_pos;
               r_last_grant <= w_sel_idx;
            end
         end

         r_pulse <= (r_state == ST_SLOT) && w_cur_vld && (r_slot_cnt == w_cur_pos);

         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state    <= ST_SYNC;
                  r_sync_cnt <= '0;
                  r_sync     <= 1'b1;
                  r_fstart   <= 1'b1;
               end
            end
            ST_SYNC: begin
               if (w_tick) begin
                  if (r_sync_cnt == SYNC_LAST) begin
                     r_state    <= ST_SLOT;
                     r_sync     <= 1'b0;
                     r_slot_idx <= '0;
                     r_slot_cnt <= '0;
                     r_arb      <= 1'b1;
                     r_slot_vld <= 1'b0;
                  end else begin
                     r_sync_cnt <= r_sync_cnt + POS_W'(1);
                  end
               end
            end
            ST_SLOT: begin
               if (w_tick) begin
                  // 8-bit counter wraps to 0 on its own at the slot boundary.
                  r_slot_cnt <= r_slot_cnt + POS_W'(1);
                  if (r_slot_cnt == SLOT_LAST) begin
                     r_slot_vld <= 1'b0;
                     if (r_slot_idx < LAST_CH) begin
                        r_slot_idx <= r_slot_idx + IDX_W'(1);
                        r_arb      <= 1'b1;
                     end else begin
                        r_slot_idx <= '0;
                        if (w_start) begin
                           r_state    <= ST_SYNC;
                           r_sync_cnt <= '0;
                           r_sync     <= 1'b1;
                           r_fstart   <= 1'b1;
                        end else begin
                           r_state <= ST_IDLE;
                        end
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = w_arb_clk ? w_grant : '0;
   assign pulse_out   = r_pulse;
   assign sync_out    = r_sync;
   assign frame_start = r_fstart;
   assign busy        = (r_state != ST_IDLE);
   assign slot_idx    = r_slot_idx;

endmodule
